ocram_mp_arb: RTL and testbench
===============================

OCRAM_MP_ARB -- requirements
Module: ocram_mp_arb

Interface
REQ-001 The block SHALL have parameter NPORT, default 2, number of requester channels, legal 1..8.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, data bits per word, legal 32 or 64.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 17, byte-address bits; depth = 2^ADDR_WIDTH / (DATA_WIDTH/8) words.
REQ-004 The block SHALL have parameter RD_LAT, default 1, read latency in cycles, legal 1..4.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 The ports SHALL be as follows:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- req, input, NPORT, per-port access request.
- we, input, NPORT, per-port write (1) / read (0).
- addr, input, NPORT*ADDR_WIDTH, per-port byte address, port i in slice i.
- be, input, NPORT*DATA_WIDTH/8, per-port byte enables.
- wdata, input, NPORT*DATA_WIDTH, per-port write data.
- gnt, output, NPORT, one-hot grant, same cycle as the accepted request.
- rvalid, output, NPORT, per-port read-data-valid pulse.
- rdata, output, DATA_WIDTH, shared read data bus.

Function
REQ-007 The block SHALL accept at most one access per cycle into a single-port word array shared by all ports.
REQ-008 gnt SHALL be combinational from req and the priority pointer; at most one bit high; gnt[i] only if req[i].
REQ-009 Arbitration SHALL be round-robin: search starts at pointer p, ascending modulo NPORT; first requesting port wins.
REQ-010 After a grant to port i, p SHALL become (i+1) mod NPORT; with no grant, p SHALL hold.
REQ-011 A requester SHALL hold req, we, addr, be and wdata stable until gnt; the block does not buffer ungranted requests.
REQ-012 Word index SHALL be addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; lower address bits are ignored.
REQ-013 A granted write SHALL update only the byte lanes with be=1 at the grant edge; be=0 writes still receive gnt and change nothing.
REQ-014 A granted write SHALL produce no rvalid.
REQ-015 A granted read SHALL raise rvalid[i] for exactly one cycle, RD_LAT cycles after the grant cycle, with rdata carrying the word as of the grant edge.
REQ-016 Read latency SHALL be implemented as an RD_LAT-stage pipeline of {valid, port id, data}; back-to-back reads from any ports SHALL stream at one result per cycle, in grant order.
REQ-017 A read granted in the cycle after a write to the same word SHALL return the written data.
REQ-018 When no rvalid bit is high, rdata SHALL hold its last value.
REQ-019 With NPORT=1, p SHALL be constant 0 and gnt SHALL equal req.

Reset
REQ-020 While rst=1, gnt and rvalid SHALL be all zero and no write SHALL occur.
REQ-021 On the edge where rst=1: p SHALL become 0, all pipeline valid bits SHALL clear, and rdata SHALL become 0.
REQ-022 Reset SHALL NOT clear the memory array; contents are preserved, and undefined after power-up.
REQ-023 Reads in flight when reset asserts SHALL be discarded and SHALL never produce rvalid.

Verification
REQ-024 NPORT=2, RD_LAT=1: port0 writes 0x1122334455667788 to addr 0x40 with be=0xFF, then reads 0x40 -> rvalid[0] exactly 1 cycle after gnt, rdata=0x1122334455667788.
REQ-025 be=0x0F write of 0xAAAAAAAAAAAAAAAA over 0x1122334455667788, then read -> rdata=0x11223344AAAAAAAA.
REQ-026 NPORT=4: all four ports hold req for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3.
REQ-027 RD_LAT=3: port1 reads addrs 0x0, 0x8, 0x10 on consecutive cycles -> three consecutive rvalid[1] pulses, starting 3 cycles after the first gnt, in address order.
REQ-028 rst asserted 1 cycle after a read gnt with RD_LAT=2 -> no rvalid; after release, a read of the pre-reset written address returns the pre-reset data.
REQ-029 Write to addr 0x100 in cycle n, read 0x100 in cycle n+1 from the other port -> rvalid carries the new data.

Source files
------------

// File: rtl/ocram_mp_arb.sv
// Multi-port round-robin arbiter in front of a single-port on-chip RAM.
// One access per cycle. Reads return through an RD_LAT-deep result pipeline.
module ocram_mp_arb #(
    parameter int unsigned NPORT      = 2,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NPORT-1:0]               req,
    input  logic [NPORT-1:0]               we,
    input  logic [NPORT*ADDR_WIDTH-1:0]    addr,
    input  logic [NPORT*DATA_WIDTH/8-1:0]  be,
    input  logic [NPORT*DATA_WIDTH-1:0]    wdata,
    output logic [NPORT-1:0]               gnt,
    output logic [NPORT-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]          rdata
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned OFFS  = $clog2(NB);
    localparam int unsigned WAW   = ADDR_WIDTH - OFFS;
    localparam int unsigned DEPTH = 1 << WAW;
    localparam int unsigned PW    = (NPORT > 1) ? $clog2(NPORT) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         ptr;
    logic [PW-1:0]         sel;
    logic [PW-1:0]         hi_sel;
    logic [PW-1:0]         lo_sel;
    logic                  hi_found;
    logic                  lo_found;
    logic                  hit;

    logic                  acc_we;
    logic [WAW-1:0]        acc_idx;
    logic [NB-1:0]         acc_be;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  unused_lo;

    logic                  hd_vld;
    logic [DATA_WIDTH-1:0] hd_data;

    logic                  lin_vld;
    logic [PW-1:0]         lin_port;
    logic [DATA_WIDTH-1:0] lin_data;

    logic [NPORT-1:0]      rvalid_q;

    // Round-robin search: first requester at or above ptr, else first requester from 0.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int j = 0; j < NPORT; j++) begin
            if (req[j] && !hi_found && (PW'(j) >= ptr)) begin
                hi_found = 1'b1;
                hi_sel   = PW'(j);
            end
            if (req[j] && !lo_found) begin
                lo_found = 1'b1;
                lo_sel   = PW'(j);
            end
        end
        hit = (hi_found || lo_found) && !rst;
        sel = hi_found ? hi_sel : lo_sel;
    end

    // One-hot grant and mux of the winning port's access fields.
    always_comb begin
        gnt       = '0;
        acc_we    = 1'b0;
        acc_idx   = '0;
        acc_be    = '0;
        acc_wdata = '0;
        unused_lo = 1'b0;
        for (int j = 0; j < NPORT; j++) begin
            unused_lo = unused_lo ^ (^addr[j*ADDR_WIDTH +: OFFS]);
            if (hit && (sel == PW'(j))) begin
                gnt[j]    = 1'b1;
                acc_we    = we[j];
                acc_idx   = addr[j*ADDR_WIDTH+OFFS +: WAW];
                acc_be    = be[j*NB +: NB];
                acc_wdata = wdata[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Priority pointer advances past the granted port, holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (hit) begin
            if (sel == PW'(NPORT - 1)) ptr <= '0;
            else                       ptr <= sel + PW'(1);
        end
    end

    // Byte-lane write; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (hit && acc_we) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_be[b]) mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
            end
        end
    end

    // Read result entering the pipeline at the grant edge.
    always_comb begin
        hd_vld  = hit && !acc_we;
        hd_data = mem[acc_idx];
    end

    if (RD_LAT == 1) begin : g_direct
        // Single-cycle latency feeds the output register directly.
        always_comb begin
            lin_vld  = hd_vld;
            lin_port = sel;
            lin_data = hd_data;
        end
    end else begin : g_pipe
        logic [RD_LAT-2:0]     st_vld;
        logic [PW-1:0]         st_port [RD_LAT-1];
        logic [DATA_WIDTH-1:0] st_data [RD_LAT-1];

        // Valid bits of the intermediate stages; cleared to drop in-flight reads.
        always_ff @(posedge clk) begin
            if (rst) begin
                st_vld <= '0;
            end else begin
                st_vld[0] <= hd_vld;
                for (int k = 1; k < RD_LAT - 1; k++) st_vld[k] <= st_vld[k-1];
            end
        end

        // Port id and data ride alongside the valid bits.
        always_ff @(posedge clk) begin
            st_port[0] <= sel;
            st_data[0] <= hd_data;
            for (int k = 1; k < RD_LAT - 1; k++) begin
                st_port[k] <= st_port[k-1];
                st_data[k] <= st_data[k-1];
            end
        end

        always_comb begin
            lin_vld  = st_vld[RD_LAT-2];
            lin_port = st_port[RD_LAT-2];
            lin_data = st_data[RD_LAT-2];
        end
    end

    // Final stage: per-port valid pulse and a shared data bus that holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata    <= '0;
        end else begin
            for (int j = 0; j < NPORT; j++) rvalid_q[j] <= lin_vld && (lin_port == PW'(j));
            if (lin_vld) rdata <= lin_data;
        end
    end

    // No valid pulse may escape while reset is held.
    always_comb begin
        rvalid = rst ? '0 : rvalid_q;
    end

endmodule

// File: tb/tb_ocram_mp_arb.sv
// Bench for ocram_mp_arb: three instances (2 ports/lat 1, 4 ports/lat 3, 1 port/lat 2)
// driven in lockstep and compared every cycle against a transaction-level model.
module tb_ocram_mp_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  t_req  [3];
    logic [3:0]  t_we   [3];
    logic [16:0] t_addr [3][4];
    logic [7:0]  t_be   [3][4];
    logic [63:0] t_wd   [3][4];

    logic [3:0]  o_gnt [3];
    logic [3:0]  o_rv  [3];
    logic [63:0] o_rd  [3];

    logic [1:0]  gnt_a, rv_a;
    logic [63:0] rd_a;
    logic [3:0]  gnt_b, rv_b;
    logic [63:0] rd_b;
    logic        gnt_c, rv_c;
    logic [63:0] rd_c;

    ocram_mp_arb #(.NPORT(2), .DATA_WIDTH(64), .ADDR_WIDTH(17), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .req(t_req[0][1:0]), .we(t_we[0][1:0]),
        .addr({t_addr[0][1], t_addr[0][0]}), .be({t_be[0][1], t_be[0][0]}),
        .wdata({t_wd[0][1], t_wd[0][0]}), .gnt(gnt_a), .rvalid(rv_a), .rdata(rd_a));

    ocram_mp_arb #(.NPORT(4), .DATA_WIDTH(64), .ADDR_WIDTH(12), .RD_LAT(3)) u_b (
        .clk(clk), .rst(rst), .req(t_req[1]), .we(t_we[1]),
        .addr({t_addr[1][3][11:0], t_addr[1][2][11:0], t_addr[1][1][11:0], t_addr[1][0][11:0]}),
        .be({t_be[1][3], t_be[1][2], t_be[1][1], t_be[1][0]}),
        .wdata({t_wd[1][3], t_wd[1][2], t_wd[1][1], t_wd[1][0]}),
        .gnt(gnt_b), .rvalid(rv_b), .rdata(rd_b));

    ocram_mp_arb #(.NPORT(1), .DATA_WIDTH(64), .ADDR_WIDTH(12), .RD_LAT(2)) u_c (
        .clk(clk), .rst(rst), .req(t_req[2][0]), .we(t_we[2][0]),
        .addr(t_addr[2][0][11:0]), .be(t_be[2][0]), .wdata(t_wd[2][0]),
        .gnt(gnt_c), .rvalid(rv_c), .rdata(rd_c));

    assign o_gnt[0] = {2'b00, gnt_a};
    assign o_gnt[1] = gnt_b;
    assign o_gnt[2] = {3'b000, gnt_c};
    assign o_rv[0]  = {2'b00, rv_a};
    assign o_rv[1]  = rv_b;
    assign o_rv[2]  = {3'b000, rv_c};
    assign o_rd[0]  = rd_a;
    assign o_rd[1]  = rd_b;
    assign o_rd[2]  = rd_c;

    typedef struct {
        int          d;
        int          due;
        int          port;
        logic [63:0] data;
    } rd_t;

    int          np  [3];
    int          lat [3];
    int          ptr [3];
    int          win [3];
    logic [63:0] last_rd [3];
    logic [63:0] mmem [int];
    rd_t         q [$];
    int          cyc;
    int          total;
    int          bad;
    logic [63:0] pre [3][10];
    int          wl  [10];
    bit          pend [3][4];

    function automatic int key(int d, logic [16:0] a);
        return d * (1 << 20) + int'(a >> 3);
    endfunction

    task automatic chk(string tag, int d, logic [63:0] obs, logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, want);
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            t_req[d] = 4'b0;
            t_we[d]  = 4'b0;
        end
    endtask

    task automatic drv(int d, int p, logic w, logic [16:0] a, logic [7:0] b, logic [63:0] x);
        t_req[d][p]  = 1'b1;
        t_we[d][p]   = w;
        t_addr[d][p] = a;
        t_be[d][p]   = b;
        t_wd[d][p]   = x;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Compare every instance against the model for this cycle, then apply the coming edge.
    task automatic sc();
        #2;
        for (int d = 0; d < 3; d++) begin
            int          w;
            int          h;
            int          k;
            logic [3:0]  eg;
            logic [3:0]  erv;
            logic [63:0] erd;
            logic [63:0] m;
            w = -1;
            if (!rst) begin
                for (int i = 0; i < np[d]; i++) begin
                    int j;
                    j = (ptr[d] + i) % np[d];
                    if (w < 0 && t_req[d][j]) w = j;
                end
            end
            win[d] = w;
            eg = (w >= 0) ? 4'(1 << w) : 4'b0;
            chk("gnt", d, 64'(o_gnt[d]), 64'(eg));
            erv = 4'b0;
            erd = last_rd[d];
            h = -1;
            foreach (q[i]) begin
                if (q[i].d == d && q[i].due == cyc) begin
                    h   = i;
                    erd = q[i].data;
                    if (!rst) erv = 4'(1 << q[i].port);
                end
            end
            chk("rvalid", d, 64'(o_rv[d]), 64'(erv));
            chk("rdata", d, o_rd[d], erd);
            if (h >= 0) begin
                last_rd[d] = erd;
                q.delete(h);
            end
            if (rst) begin
                ptr[d]     = 0;
                last_rd[d] = 64'h0;
                for (int i = q.size() - 1; i >= 0; i--) if (q[i].d == d) q.delete(i);
            end else if (w >= 0) begin
                k = key(d, t_addr[d][w]);
                if (t_we[d][w]) begin
                    m = mmem.exists(k) ? mmem[k] : 64'h0;
                    for (int b = 0; b < 8; b++)
                        if (t_be[d][w][b]) m[b*8 +: 8] = t_wd[d][w][b*8 +: 8];
                    mmem[k] = m;
                end else begin
                    q.push_back('{d, cyc + lat[d], w, mmem[k]});
                end
                ptr[d] = (w + 1) % np[d];
            end
        end
        cyc++;
    endtask

    initial begin
        np  = '{2, 4, 1};
        lat = '{1, 3, 2};
        wl  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 32};
        total = 0;
        bad   = 0;
        cyc   = 0;
        for (int d = 0; d < 3; d++) begin
            ptr[d]     = 0;
            last_rd[d] = 64'h0;
            for (int p = 0; p < 4; p++) begin
                t_addr[d][p] = 17'h0;
                t_be[d][p]   = 8'h0;
                t_wd[d][p]   = 64'h0;
                pend[d][p]   = 1'b0;
            end
        end
        idle();
        rst = 1'b1;
        adv();
        sc();
        adv();
        rst = 1'b0;

        // Preload ten words per instance through port 0, with junk in the ignored low bits.
        for (int i = 0; i < 10; i++) begin
            idle();
            for (int d = 0; d < 3; d++) begin
                pre[d][i] = {$urandom, $urandom};
                drv(d, 0, 1'b1, 17'((wl[i] << 3) | $urandom_range(0, 7)), 8'hFF, pre[d][i]);
            end
            sc();
            adv();
        end

        // Requests held during reset must be neither granted nor written.
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            idle();
            for (int d = 0; d < 3; d++)
                for (int p = 0; p < np[d]; p++) drv(d, p, 1'b1, 17'h0, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
            sc();
            adv();
        end
        rst = 1'b0;

        // Full write, read, partial write, read-after-write from the other port, be=0 write.
        idle(); drv(0, 0, 1'b1, 17'h40, 8'hFF, 64'h1122334455667788); sc();
        chk("wr_gnt", 0, 64'(o_gnt[0]), 64'h1); adv();
        idle(); drv(0, 0, 1'b0, 17'h40, 8'h00, 64'h0); sc();
        chk("rd_gnt", 0, 64'(o_gnt[0]), 64'h1); adv();
        idle(); drv(0, 0, 1'b1, 17'h40, 8'h0F, 64'hAAAAAAAAAAAAAAAA); sc();
        chk("full_rv", 0, 64'(o_rv[0]), 64'h1);
        chk("full_rd", 0, o_rd[0], 64'h1122334455667788); adv();
        idle(); drv(0, 0, 1'b0, 17'h44, 8'h00, 64'h0); sc(); adv();
        idle(); drv(0, 0, 1'b1, 17'h100, 8'hFF, 64'hCAFE_F00D_0BAD_BEEF); sc();
        chk("part_rv", 0, 64'(o_rv[0]), 64'h1);
        chk("part_rd", 0, o_rd[0], 64'h11223344AAAAAAAA); adv();
        idle(); drv(0, 1, 1'b0, 17'h100, 8'h00, 64'h0); sc();
        chk("raw_gnt", 0, 64'(o_gnt[0]), 64'h2); adv();
        idle(); drv(0, 0, 1'b1, 17'h40, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF); sc();
        chk("raw_rv", 0, 64'(o_rv[0]), 64'h2);
        chk("raw_rd", 0, o_rd[0], 64'hCAFE_F00D_0BAD_BEEF); adv();
        idle(); drv(0, 0, 1'b0, 17'h40, 8'h00, 64'h0); sc(); adv();
        idle(); sc();
        chk("be0_rv", 0, 64'(o_rv[0]), 64'h1);
        chk("be0_rd", 0, o_rd[0], 64'h11223344AAAAAAAA); adv();

        // Four ports requesting continuously after reset rotate 0,1,2,3,0,1,2,3.
        idle(); rst = 1'b1; sc(); adv(); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idle();
            for (int p = 0; p < 4; p++) drv(1, p, 1'b0, 17'(p * 8), 8'h00, 64'h0);
            sc();
            chk("rr_gnt", 1, 64'(o_gnt[1]), 64'(1 << (k % 4)));
            adv();
        end
        for (int k = 0; k < 4; k++) begin idle(); sc(); adv(); end

        // Three back-to-back reads on port 1 stream out three cycles later in order.
        for (int k = 0; k < 6; k++) begin
            idle();
            if (k < 3) drv(1, 1, 1'b0, 17'(k * 8), 8'h00, 64'h0);
            sc();
            if (k >= 3) begin
                chk("str_rv", 1, 64'(o_rv[1]), 64'h2);
                chk("str_rd", 1, o_rd[1], pre[1][k-3]);
            end else begin
                chk("str_rv0", 1, 64'(o_rv[1]), 64'h0);
            end
            adv();
        end

        // Reset one cycle after a read grant discards it but keeps memory contents.
        idle(); drv(2, 0, 1'b1, 17'h28, 8'hFF, 64'h0123_4567_89AB_CDEF); sc(); adv();
        idle(); drv(2, 0, 1'b0, 17'h28, 8'h00, 64'h0); sc();
        chk("rst_rdgnt", 2, 64'(o_gnt[2]), 64'h1); adv();
        idle(); drv(2, 0, 1'b0, 17'h30, 8'h00, 64'h0); rst = 1'b1; sc();
        chk("rst_gnt", 2, 64'(o_gnt[2]), 64'h0);
        chk("rst_rv", 2, 64'(o_rv[2]), 64'h0); adv(); rst = 1'b0;
        idle(); sc();
        chk("drop_rv", 2, 64'(o_rv[2]), 64'h0);
        chk("rst_rd", 2, o_rd[2], 64'h0); adv();
        idle(); drv(2, 0, 1'b0, 17'h28, 8'h00, 64'h0); sc(); adv();
        idle(); sc(); adv();
        idle(); sc();
        chk("keep_rv", 2, 64'(o_rv[2]), 64'h1);
        chk("keep_rd", 2, o_rd[2], 64'h0123_4567_89AB_CDEF); adv();

        // Random traffic: requests held until granted, occasional reset.
        idle();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int d = 0; d < 3; d++) begin
                for (int p = 0; p < np[d]; p++) begin
                    if (!pend[d][p] && $urandom_range(0, 1) == 1) begin
                        pend[d][p] = 1'b1;
                        t_we[d][p]   = 1'($urandom_range(0, 1));
                        t_addr[d][p] = 17'(($urandom_range(0, 7) << 3) | $urandom_range(0, 7));
                        t_be[d][p]   = 8'($urandom);
                        t_wd[d][p]   = {$urandom, $urandom};
                    end
                    t_req[d][p] = pend[d][p];
                end
            end
            sc();
            for (int d = 0; d < 3; d++) if (win[d] >= 0) pend[d][win[d]] = 1'b0;
            adv();
        end
        rst = 1'b0;
        idle();
        for (int c = 0; c < 5; c++) begin sc(); adv(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
